// File: rtl/dice_roller.sv
// Two-dice roller: draws faces 1..6 from an external LFSR by rejection sampling.
// Optional macro DICE_TIMEOUT_EN bounds rejection to MAX_TRIES per die.
module dice_roller #(
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rnd,
  output logic       lfsr_en,
  input  logic       roll_req,
  output logic       busy,
  output logic       result_valid,
  input  logic       result_ack,
  output logic [2:0] die1,
  output logic [2:0] die2,
  output logic [3:0] sum,
  output logic       is_natural,
  output logic       is_craps
);

  typedef enum logic [1:0] {IDLE, DRAW1, DRAW2, DONE} state_t;

  state_t     state;
  logic [2:0] f1, f2;
  logic [2:0] face1, face2;
  logic       acc1, acc2;
  logic       forced;
  logic [3:0] sum_n;
  logic       unused_rnd;

  assign f1         = rnd[2:0];
  assign f2         = rnd[6:4];
  assign unused_rnd = ^{rnd[7], rnd[3]};
  assign lfsr_en    = (state != DONE);

  if (MAX_TRIES < 1) begin : g_bad_tries
    $error("MAX_TRIES must be at least 1");
  end

`ifdef DICE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_TRIES + 1);
  logic [CW-1:0] tries;
  logic          drawing;
  logic          accepting;

  assign forced    = (tries == CW'(MAX_TRIES));
  assign drawing   = (state == DRAW1) || (state == DRAW2);
  assign accepting = (state == DRAW1) ? acc1 : acc2;

  // Counts consecutive rejects of the die currently being drawn; any accept
  // or leaving the draw states clears it, so each die starts from zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      tries <= '0;
    else if (drawing && !accepting) tries <= tries + 1'b1;
    else                            tries <= '0;
  end
`else
  assign forced = 1'b0;
`endif

  always_comb begin
    acc1  = (f1 <= 3'd5) || forced;
    acc2  = (f2 <= 3'd5) || forced;
    face1 = (f1 <= 3'd5) ? f1 + 3'd1 : f1 - 3'd5;
    face2 = (f2 <= 3'd5) ? f2 + 3'd1 : f2 - 3'd5;
    sum_n = {1'b0, die1} + {1'b0, face2};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      die1         <= '0;
      die2         <= '0;
      sum          <= '0;
      is_natural   <= 1'b0;
      is_craps     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (roll_req) begin
            state <= DRAW1;
            busy  <= 1'b1;
          end
        end
        DRAW1: begin
          if (acc1) begin
            die1  <= face1;
            state <= DRAW2;
          end
        end
        DRAW2: begin
          if (acc2) begin
            die2         <= face2;
            sum          <= sum_n;
            is_natural   <= (sum_n == 4'd7) || (sum_n == 4'd11);
            is_craps     <= (sum_n == 4'd2) || (sum_n == 4'd3) || (sum_n == 4'd12);
            state        <= DONE;
            busy         <= 1'b0;
            result_valid <= 1'b1;
          end
        end
        DONE: begin
          if (result_ack) begin
            state        <= IDLE;
            result_valid <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dice_roller.sv
// Scoreboard bench for dice_roller: stimulus pushes model predictions, a monitor
// pops and compares whenever result_valid rises.
module tb_dice_roller;

  localparam int unsigned TB_TRIES = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rnd = '0;
  logic       lfsr_en;
  logic       roll_req = 1'b0;
  logic       busy;
  logic       result_valid;
  logic       result_ack = 1'b0;
  logic [2:0] die1, die2;
  logic [3:0] sum;
  logic       is_natural, is_craps;

  dice_roller #(.MAX_TRIES(TB_TRIES)) dut (
    .clock(clock), .reset(reset), .rnd(rnd), .lfsr_en(lfsr_en),
    .roll_req(roll_req), .busy(busy), .result_valid(result_valid),
    .result_ack(result_ack), .die1(die1), .die2(die2), .sum(sum),
    .is_natural(is_natural), .is_craps(is_craps)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int d1, d2, s, nat, craps, lat, at;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: scan the per-cycle rnd stream for the first usable field of each die.
  function automatic exp_t model(input logic [7:0] s[$]);
    exp_t        e;
    int unsigned i = 0;
    int unsigned tries = 0;
    logic [7:0]  b;
    int          f;
    bit          timeout = 1'b0;
`ifdef DICE_TIMEOUT_EN
    timeout = 1'b1;
`endif
    e.d1 = 0;
    e.d2 = 0;
    while (e.d1 == 0 && i < s.size()) begin
      b = s[i];
      f = int'(b % 8);
      if (f <= 5) e.d1 = f + 1;
      else if (timeout && tries == TB_TRIES) e.d1 = f - 5;
      else tries++;
      i++;
    end
    tries = 0;
    while (e.d2 == 0 && i < s.size()) begin
      b = s[i];
      f = int'((b / 16) % 8);
      if (f <= 5) e.d2 = f + 1;
      else if (timeout && tries == TB_TRIES) e.d2 = f - 5;
      else tries++;
      i++;
    end
    e.s     = e.d1 + e.d2;
    e.nat   = (e.s == 7 || e.s == 11) ? 1 : 0;
    e.craps = (e.s == 2 || e.s == 3 || e.s == 12) ? 1 : 0;
    e.lat   = int'(i);
    e.at    = 0;
    return e;
  endfunction

  always @(negedge clock) begin
    if (result_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=valid required=none at t=%0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("die1", die1, e.d1);
        chk("die2", die2, e.d2);
        chk("sum", sum, e.s);
        chk("is_natural", is_natural, e.nat);
        chk("is_craps", is_craps, e.craps);
        chk("latency_edge", cyc, e.at);
      end
    end
    prev_v = result_valid;
  end

  task automatic do_roll(input logic [7:0] s[$], input int hold,
                         input bit req_in_done, input bit req_with_ack);
    exp_t e;
    bit   got = 1'b0;
    e = model(s);
    roll_req = 1'b1;
    @(posedge clock); #1;
    roll_req = 1'b0;
    chk("busy_after_req", busy, 1);
    e.at = cyc + e.lat;
    exp_q.push_back(e);
    for (int k = 0; k < s.size(); k++) begin
      rnd = s[k];
      @(posedge clock); #1;
      if (result_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("valid_reached", got, 1);
    for (int h = 0; h < hold; h++) begin
      chk("lfsr_en_done", lfsr_en, 0);
      chk("busy_done", busy, 0);
      roll_req = req_in_done;
      @(posedge clock); #1;
      chk("valid_held", result_valid, 1);
    end
    roll_req   = req_with_ack;
    result_ack = 1'b1;
    @(posedge clock); #1;
    result_ack = 1'b0;
    roll_req   = 1'b0;
    chk("valid_after_ack", result_valid, 0);
    chk("busy_after_ack", busy, 0);
    chk("lfsr_en_idle", lfsr_en, 1);
    chk("die1_held", die1, e.d1);
    chk("sum_held", sum, e.s);
    @(posedge clock); #1;
    chk("no_queued_roll", busy, 0);
  endtask

  initial begin
    logic [7:0] s[$];

    #12;
    chk("rst_die1", die1, 0);
    chk("rst_die2", die2, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {is_natural, is_craps}, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lfsr_en", lfsr_en, 1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    s = '{8'h03, 8'h20};                      do_roll(s, 1, 1'b0, 1'b0);
    s = '{8'h07, 8'h06, 8'h00, 8'h00};        do_roll(s, 2, 1'b1, 1'b0);
    s = '{8'h05, 8'h50};                      do_roll(s, 10, 1'b1, 1'b1);
    s = '{8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h00, 8'h00};
    do_roll(s, 0, 1'b0, 1'b1);

    // Async reset while in DRAW2 must clear everything before any clock edge.
    roll_req = 1'b1;
    @(posedge clock); #1;
    roll_req = 1'b0;
    rnd = 8'h72;
    @(posedge clock); #1;
    chk("busy_in_draw2", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_valid", result_valid, 0);
    chk("async_dice", {die1, die2}, 0);
    chk("async_sum", sum, 0);
    chk("async_flags", {is_natural, is_craps}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      chk("post_rst_idle", {busy, result_valid}, 0);
    end

    for (int r = 0; r < 40; r++) begin
      s = {};
      for (int k = 0; k < 6 + int'($urandom_range(0, 10)); k++) s.push_back(8'($urandom));
      s.push_back(8'h00);
      s.push_back(8'h00);
      do_roll(s, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end

    repeat (3) @(posedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dice_roller.md
DICE_ROLLER -- requirements
Module: dice_roller

Interface
REQ-001 SHALL have parameter: MAX_TRIES, default 8, consecutive rejected draws per die before forced accept (used only with DICE_TIMEOUT_EN).
REQ-002 SHALL have port: clock  input  1  rising-edge system clock.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: rnd  input  8  current LFSR value.
REQ-005 SHALL have port: lfsr_en  output  1  clock enable to the LFSR.
REQ-006 SHALL have port: roll_req  input  1  request a new roll.
REQ-007 SHALL have port: busy  output  1  roll in progress (DRAW1/DRAW2).
REQ-008 SHALL have port: result_valid  output  1  die1/die2/sum/flags valid, held until acked.
REQ-009 SHALL have port: result_ack  input  1  consumer accepts result.
REQ-010 SHALL have port: die1, die2  output  3 each  die faces, 1..6.
REQ-011 SHALL have port: sum  output  4  die1+die2, 2..12.
REQ-012 SHALL have port: is_natural, is_craps  output  1 each  sum in {7,11}; sum in {2,3,12}.

Function
REQ-013 SHALL implement states IDLE, DRAW1, DRAW2, DONE.
REQ-014 IDLE: roll_req=1 -> DRAW1 next edge; otherwise stay.
REQ-015 DRAW1: field f=rnd[2:0] sampled each cycle; f<=5 -> die1<=f+1, go DRAW2; f>=6 -> reject, stay.
REQ-016 DRAW2: field f=rnd[6:4] sampled each cycle; f<=5 -> die2<=f+1, go DONE; f>=6 -> reject, stay.
REQ-017 On DRAW2 accept, same edge SHALL register sum, is_natural, is_craps from the new die2 and held die1.
REQ-018 result_valid SHALL be 1 exactly in DONE; busy SHALL be 1 exactly in DRAW1/DRAW2.
REQ-019 DONE: result_ack=1 -> IDLE next edge; result registers hold their values until the next DRAW2 accept.
REQ-020 Minimum latency: roll_req sampled at edge N, result_valid high after edge N+2 (no rejects); each reject adds one cycle.
REQ-021 lfsr_en SHALL be decoded from state: 1 in IDLE, DRAW1, DRAW2; 0 in DONE (LFSR frozen while a result is pending).
REQ-022 roll_req outside IDLE SHALL be ignored, not queued.
REQ-023 result_ack outside DONE SHALL be ignored.
REQ-024 roll_req and result_ack both 1 in DONE: ack honoured -> IDLE; the roll_req is not accepted that cycle.
REQ-025 sum SHALL be computed at 4-bit width with no overflow (max 12).

Reset
REQ-026 reset asserted SHALL force IDLE immediately, regardless of clock.
REQ-027 Reset values: die1=0, die2=0, sum=0, is_natural=0, is_craps=0, result_valid=0, busy=0; lfsr_en per REQ-021 (1).
REQ-028 reset mid-roll (DRAW1/DRAW2/DONE) SHALL discard the partial or pending result; no result_valid after release without a new roll_req.
REQ-029 Reject counters (when present) SHALL reset to 0.

Configuration
REQ-030 Macro DICE_TIMEOUT_EN defined: per-die reject counter; cleared on entering DRAW1/DRAW2; after MAX_TRIES consecutive rejects the next draw is force-accepted as f-5 (6->1, 7->2) and counter cleared.
REQ-031 Macro DICE_TIMEOUT_EN undefined: no counter logic, rejection unbounded, MAX_TRIES unused.

Verification
REQ-032 roll_req pulse; rnd=0x03 in DRAW1, 0x20 in DRAW2 -> die1=4, die2=3, sum=7, is_natural=1, is_craps=0, result_valid 2 cycles after request edge.
REQ-033 DRAW1 rnd sequence 0x07, 0x06, 0x00, then DRAW2 rnd=0x00 -> two rejects, busy 4 cycles, die1=1, die2=1, sum=2, is_craps=1.
REQ-034 rnd=0x05 then 0x50 -> die1=6, die2=6, sum=12, is_craps=1; lfsr_en=0 while result_valid=1; result held 10 cycles until result_ack, then IDLE.
REQ-035 DICE_TIMEOUT_EN, MAX_TRIES=4, rnd[2:0] held 7 in DRAW1 -> 4 rejects then die1=2 on 5th draw; without macro, remains in DRAW1 indefinitely.
REQ-036 reset asserted in DRAW2 -> all outputs zero, IDLE; roll_req while result_valid=1 ignored; roll_req+result_ack together in DONE -> IDLE, no new roll.
